lsu_byte_serial: RTL

- Load/store unit sitting directly upstream of the byte-wide data memory.
- Accepts byte/half/word load and store requests from the core's MEM stage and serialises each into 1, 2 or 4 single-byte memory accesses.
- Assembles load bytes little-endian and sign/zero-extends the result.
- Returns a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_load_extend.sv | 21 ++
 rtl/lsu_byte_serial.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and helper functions for the byte-serial LSU.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned NB_W   = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    // Request attributes captured at acceptance (address kept separately, it is parameterised).
    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              is_unsigned;
        logic [DATA_W-1:0] wdata;
    } req_attr_t;

    // Number of byte accesses for a size code; 2'b11 behaves as a word.
    function automatic logic [NB_W-1:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_B:    return NB_W'(1);
            SZ_H:    return NB_W'(2);
            default: return NB_W'(4);
        endcase
    endfunction

    // Natural-alignment test on the low address bits.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the little-endian load assembly register.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] rdata_c
);

    // Pick the significant bytes and replicate the sign bit unless unsigned.
    always_comb begin
        rdata_c = raw;
        case (size)
            SZ_B:    rdata_c = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_H:    rdata_c = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: rdata_c = raw;
        endcase
    end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit in front of a byte-wide data memory.
// Splits byte/half/word requests into single-byte accesses, reassembles loads.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests complete at once with resp_err=1
// and never touch memory; otherwise they are serialised like any other request.
module lsu_byte_serial
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    state_t            state_q, state_n;
    req_attr_t         attr_q, attr_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [NB_W-1:0]   nbytes_q, nbytes_n;
    logic [DATA_W-1:0] asm_q, asm_n;

    logic              req_ready_q, req_ready_n;
    logic              resp_valid_q, resp_valid_n;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_n;
    logic              resp_err_q, resp_err_n;
    logic              mem_read_q, mem_read_n;
    logic              mem_write_q, mem_write_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_n;

    logic              last_c;
    logic              trap_c;
    logic [DATA_W-1:0] ext_c;
    logic              mem_rd_unused;

    // Memory returns a sign-extended byte; only the byte itself is meaningful here.
    assign mem_rd_unused = ^mem_rd[DATA_W-1:8];

    // Final access of the current request.
    assign last_c = (NB_W'(cnt_q) == (nbytes_q - NB_W'(1)));

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned requests bypass memory entirely.
    assign trap_c = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap_c = 1'b0;
`endif

    // Assembly register: cleared on acceptance, one byte lane filled per load access.
    always_comb begin
        asm_n = asm_q;
        if (state_q == IDLE && req_valid) begin
            asm_n = '0;
        end else if (state_q == ACCESS && !attr_q.we) begin
            asm_n[{cnt_q, 3'b000} +: 8] = mem_rd[7:0];
        end
    end

    // Extension sees the next assembly value so the final byte is included.
    lsu_load_extend u_extend (
        .raw         (asm_n),
        .size        (attr_q.size),
        .is_unsigned (attr_q.is_unsigned),
        .rdata_c     (ext_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state_q;
        attr_n       = attr_q;
        addr_n       = addr_q;
        cnt_n        = cnt_q;
        nbytes_n     = nbytes_q;
        req_ready_n  = 1'b0;
        resp_valid_n = 1'b0;
        resp_rdata_n = resp_rdata_q;
        resp_err_n   = 1'b0;
        mem_read_n   = mem_read_q;
        mem_write_n  = mem_write_q;
        mem_addr_n   = mem_addr_q;
        mem_wd_n     = mem_wd_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    attr_n = '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                               wdata: req_wdata};
                    addr_n   = req_addr;
                    cnt_n    = '0;
                    nbytes_n = size_to_nbytes(req_size);
                    if (trap_c) begin
                        state_n      = DONE;
                        resp_valid_n = 1'b1;
                        resp_rdata_n = '0;
                        resp_err_n   = 1'b1;
                        mem_read_n   = 1'b0;
                        mem_write_n  = 1'b0;
                    end else begin
                        state_n     = ACCESS;
                        mem_read_n  = ~req_we;
                        mem_write_n = req_we;
                        mem_addr_n  = req_addr;
                        mem_wd_n    = {4{req_wdata[7:0]}};
                    end
                end
            end
            ACCESS: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_n      = DONE;
                    mem_read_n   = 1'b0;
                    mem_write_n  = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = attr_q.we ? '0 : ext_c;
                end else begin
                    mem_addr_n = addr_q + ADDR_W'(cnt_n);
                    mem_wd_n   = {4{attr_q.wdata[{cnt_n, 3'b000} +: 8]}};
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n     = IDLE;
                mem_read_n  = 1'b0;
                mem_write_n = 1'b0;
            end
        endcase

        req_ready_n = (state_n == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            attr_q       <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            asm_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
        end else begin
            state_q      <= state_n;
            attr_q       <= attr_n;
            addr_q       <= addr_n;
            cnt_q        <= cnt_n;
            nbytes_q     <= nbytes_n;
            asm_q        <= asm_n;
            req_ready_q  <= req_ready_n;
            resp_valid_q <= resp_valid_n;
            resp_rdata_q <= resp_rdata_n;
            resp_err_q   <= resp_err_n;
            mem_read_q   <= mem_read_n;
            mem_write_q  <= mem_write_n;
            mem_addr_q   <= mem_addr_n;
            mem_wd_q     <= mem_wd_n;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    // Reset suppresses the negedge commit of an in-flight store byte.
    assign mem_write  = mem_write_q & ~rst;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;

endmodule
